// File: rtl/icache_burst_subsystem_pkg.sv
// Shared types, constants and geometry helpers for the instruction cache.
package icache_burst_subsystem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        C_IDLE,
        C_REQ,
        C_FILL,
        C_UPDATE
    } cache_state_e;

    typedef enum logic {
        B_IDLE,
        B_BURST
    } burst_state_e;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int num_sets(input int cache_bytes, input int ways,
                                    input int words, input int data_width);
        return cache_bytes / (ways * words * (data_width / 8));
    endfunction

    function automatic int byte_bits(input int data_width);
        return clog2_min1(data_width / 8);
    endfunction

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CACHE_SIZE = 1024;
    localparam int DEF_WAYS       = 4;
    localparam int DEF_BLOCK_SIZE = 8;

    localparam int SETS      = num_sets(DEF_CACHE_SIZE, DEF_WAYS,
                                        DEF_BLOCK_SIZE, DEF_DATA_WIDTH);
    localparam int IDX_BITS  = clog2_min1(SETS);
    localparam int OFF_BITS  = clog2_min1(DEF_BLOCK_SIZE);
    localparam int BYTE_BITS = byte_bits(DEF_DATA_WIDTH);
    localparam int TAG_BITS  = DEF_ADDR_WIDTH - IDX_BITS - OFF_BITS - BYTE_BITS;

endpackage

// File: rtl/icache_burst_subsystem_burst_controller.sv
// Line-fill beat sequencer: walks burst_len+1 consecutive words from a base,
// presenting one valid beat per cycle straight from instruction memory.
module burst_controller
    import icache_burst_subsystem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            burst_len,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic                  valid,
    output logic                  last
);

    localparam int BW = byte_bits(DATA_WIDTH);

    burst_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [3:0]            count_q;

    always_comb begin
        ready = (state_q == B_IDLE) && req;
        valid = (state_q == B_BURST);
        last  = valid && (count_q == burst_len);
        data  = mem_data;
        mem_addr = '0;
        if (valid) begin
            mem_addr = base_q + (ADDR_WIDTH'(count_q) << BW);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            B_IDLE:  if (req) state_d = B_BURST;
            B_BURST: if (last) state_d = B_IDLE;
            default: state_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= B_IDLE;
            base_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (ready) begin
                base_q  <= addr;
                count_q <= '0;
            end else if (valid) begin
                count_q <= last ? 4'd0 : count_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/icache_burst_subsystem.sv
// Set-associative instruction cache with combinational lookup and a
// burst line fill; victim is first invalid way, else per-set round robin.
module icache_burst_subsystem
    import icache_burst_subsystem_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int CACHE_SIZE    = 1024,
    parameter int ASSOCIATIVITY = 4,
    parameter int BLOCK_SIZE    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  load_use_stall_in,
    output logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  cache_hit,
    output logic                  cache_miss,
    output logic                  cache_evict
);

    localparam int NSETS  = num_sets(CACHE_SIZE, ASSOCIATIVITY,
                                     BLOCK_SIZE, DATA_WIDTH);
    localparam int IDX_W  = clog2_min1(NSETS);
    localparam int OFF_W  = clog2_min1(BLOCK_SIZE);
    localparam int BYTE_W = byte_bits(DATA_WIDTH);
    localparam int LINE_W = OFF_W + BYTE_W;
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - LINE_W;
    localparam int WAY_W  = clog2_min1(ASSOCIATIVITY);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((1 << LINE_W) - 1);
    localparam logic [DATA_WIDTH-1:0] NOP       = DATA_WIDTH'(NOP_INSTR);

    logic [ASSOCIATIVITY-1:0] valid_q [NSETS];
    logic [WAY_W-1:0]         rr_q    [NSETS];
    logic [TAG_W-1:0]         tag_q   [NSETS][ASSOCIATIVITY];
    logic [DATA_WIDTH-1:0]    data_q  [NSETS][ASSOCIATIVITY][BLOCK_SIZE];

    cache_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] miss_base_q;
    logic [WAY_W-1:0]      victim_q;
    logic                  victim_valid_q;
    logic [OFF_W-1:0]      fill_cnt_q;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [OFF_W-1:0]      req_off;
    logic                  hit_any;
    logic [WAY_W-1:0]      hit_way;
    logic                  inv_found;
    logic [WAY_W-1:0]      victim;
    logic                  lookup_hit;
    logic                  start_fill;

    logic [IDX_W-1:0]      fill_idx;
    logic [TAG_W-1:0]      fill_tag;

    logic                  bc_req;
    logic                  bc_ready;
    logic                  bc_valid;
    logic                  bc_last;
    logic [DATA_WIDTH-1:0] bc_data;

    assign req_idx  = cpu_addr[LINE_W +: IDX_W];
    assign req_tag  = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_off  = cpu_addr[BYTE_W +: OFF_W];
    assign fill_idx = miss_base_q[LINE_W +: IDX_W];
    assign fill_tag = miss_base_q[ADDR_WIDTH-1 -: TAG_W];

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Scanning downward leaves the lowest-numbered invalid way selected.
    always_comb begin
        inv_found = 1'b0;
        victim    = rr_q[req_idx];
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                victim    = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        start_fill = 1'b0;
        unique case (state_q)
            C_IDLE: begin
                if (cpu_req && !hit_any && !load_use_stall_in) begin
                    state_d    = C_REQ;
                    start_fill = 1'b1;
                end
            end
            C_REQ:    if (bc_ready) state_d = C_FILL;
            C_FILL:   if (bc_valid && bc_last) state_d = C_UPDATE;
            C_UPDATE: state_d = C_IDLE;
            default:  state_d = C_IDLE;
        endcase
    end

    // Outputs are gated by rst so they read idle while reset is held.
    always_comb begin
        lookup_hit  = rst && cpu_req && (state_q == C_IDLE) && hit_any;
        cpu_stall   = rst && cpu_req && !lookup_hit;
        cpu_data    = lookup_hit ? data_q[req_idx][hit_way][req_off] : NOP;
        cache_hit   = lookup_hit && !load_use_stall_in;
        cache_miss  = rst && start_fill;
        cache_evict = rst && (state_q == C_UPDATE) && victim_valid_q;
        bc_req      = (state_q == C_REQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= C_IDLE;
            miss_base_q    <= '0;
            victim_q       <= '0;
            victim_valid_q <= 1'b0;
            fill_cnt_q     <= '0;
            for (int s = 0; s < NSETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q <= state_d;
            if (start_fill) begin
                miss_base_q    <= cpu_addr & ~LINE_MASK;
                victim_q       <= victim;
                victim_valid_q <= !inv_found;
                fill_cnt_q     <= '0;
            end
            if (bc_valid) begin
                fill_cnt_q <= fill_cnt_q + 1'b1;
            end
            if (state_q == C_UPDATE) begin
                valid_q[fill_idx][victim_q] <= 1'b1;
                if (victim_valid_q) begin
                    rr_q[fill_idx] <= (rr_q[fill_idx] == WAY_W'(ASSOCIATIVITY - 1))
                                      ? '0 : rr_q[fill_idx] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bc_valid) begin
            data_q[fill_idx][victim_q][fill_cnt_q] <= bc_data;
        end
        if (state_q == C_UPDATE) begin
            tag_q[fill_idx][victim_q] <= fill_tag;
        end
    end

    burst_controller #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_burst (
        .clk       (clk),
        .rst       (rst),
        .req       (bc_req),
        .addr      (miss_base_q),
        .burst_len (4'(BLOCK_SIZE - 1)),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .data      (bc_data),
        .ready     (bc_ready),
        .valid     (bc_valid),
        .last      (bc_last)
    );

endmodule

// File: tb/tb_icache_burst_subsystem.sv
// Directed bench for the burst-fill instruction cache.
module tb_icache_burst_subsystem;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        load_use_stall_in;
    logic [31:0] cpu_data;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        cache_hit;
    logic        cache_miss;
    logic        cache_evict;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    assign mem_data = 32'h1000 + (mem_addr >> 2);

    icache_burst_subsystem dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_req           (cpu_req),
        .cpu_addr          (cpu_addr),
        .load_use_stall_in (load_use_stall_in),
        .cpu_data          (cpu_data),
        .cpu_stall         (cpu_stall),
        .mem_addr          (mem_addr),
        .mem_data          (mem_data),
        .cache_hit         (cache_hit),
        .cache_miss        (cache_miss),
        .cache_evict       (cache_evict)
    );

    // Holds a fetch until it hits (bounded), tallying stall cycles and pulses.
    task automatic fetch(input logic [31:0] a, output int stalls,
                         output logic [31:0] d, output int misses,
                         output int evicts, output logic hit);
        stalls = 0;
        misses = 0;
        evicts = 0;
        cpu_req  = 1'b1;
        cpu_addr = a;
        #1;
        while (cpu_stall && stalls < 40) begin
            stalls++;
            misses += int'(cache_miss);
            evicts += int'(cache_evict);
            @(negedge clk);
            #1;
        end
        d   = cpu_data;
        hit = cache_hit;
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cpu_req = 1'b1;
        cpu_addr = 32'h0;
        load_use_stall_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b expected 0", cpu_stall);
        end
        checks++;
        if (cpu_data !== NOP) begin
            errors++;
            $display("FAIL reset_data: got %h expected %h", cpu_data, NOP);
        end
        checks++;
        if (mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_addr: got %h expected 0", mem_addr);
        end
        checks++;
        if ({cache_hit, cache_miss, cache_evict} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 000",
                     {cache_hit, cache_miss, cache_evict});
        end
        @(negedge clk);
        rst = 1'b1;
        cpu_req = 1'b0;
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || cpu_data !== NOP) begin
            errors++;
            $display("FAIL noreq_idle: got stall %b data %h expected 0 %h",
                     cpu_stall, cpu_data, NOP);
        end
        @(negedge clk);
    endtask

    task automatic test_cold_fill();
        logic        exp_stall;
        logic [31:0] exp_ma;
        int          misses;
        misses = 0;
        cpu_req = 1'b1;
        cpu_addr = 32'h0;
        for (int k = 0; k <= 11; k++) begin
            #1;
            exp_stall = (k < 11);
            exp_ma = (k >= 2 && k <= 9) ? 32'(4 * (k - 2)) : 32'h0;
            checks++;
            if (cpu_stall !== exp_stall) begin
                errors++;
                $display("FAIL cold_stall c%0d: got %b expected %b",
                         k, cpu_stall, exp_stall);
            end
            checks++;
            if (mem_addr !== exp_ma) begin
                errors++;
                $display("FAIL cold_mem_addr c%0d: got %h expected %h",
                         k, mem_addr, exp_ma);
            end
            misses += int'(cache_miss);
            if (k < 11) @(negedge clk);
        end
        checks++;
        if (cpu_data !== 32'h1000 || cache_hit !== 1'b1) begin
            errors++;
            $display("FAIL cold_data: got %h hit %b expected 00001000 1",
                     cpu_data, cache_hit);
        end
        checks++;
        if (misses !== 1) begin
            errors++;
            $display("FAIL cold_miss_pulses: got %0d expected 1", misses);
        end
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic test_seq_hits();
        int          hits;
        logic [31:0] exp_d;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            cpu_req = 1'b1;
            cpu_addr = 32'(4 * i) | ((i % 2 == 1) ? 32'h3 : 32'h0);
            exp_d = 32'h1000 + 32'(i);
            #1;
            checks++;
            if (cpu_stall !== 1'b0 || cpu_data !== exp_d) begin
                errors++;
                $display("FAIL seq_hit %0d: got stall %b data %h expected 0 %h",
                         i, cpu_stall, cpu_data, exp_d);
            end
            hits += int'(cache_hit);
            @(negedge clk);
        end
        cpu_req = 1'b0;
        checks++;
        if (hits !== 8) begin
            errors++;
            $display("FAIL seq_hit_pulses: got %0d expected 8", hits);
        end
    endtask

    task automatic test_evict();
        logic [31:0] addrs [3];
        int          st, ms, ev;
        logic [31:0] d;
        logic        h;
        addrs[0] = 32'h100;
        addrs[1] = 32'h200;
        addrs[2] = 32'h300;
        foreach (addrs[i]) begin
            fetch(addrs[i], st, d, ms, ev, h);
            checks++;
            if (st !== 11 || ev !== 0 || d !== 32'h1000 + (addrs[i] >> 2)) begin
                errors++;
                $display("FAIL fill_way %h: got stall %0d evict %0d data %h expected 11 0 %h",
                         addrs[i], st, ev, d, 32'h1000 + (addrs[i] >> 2));
            end
        end
        fetch(32'h400, st, d, ms, ev, h);
        checks++;
        if (st !== 11 || ev !== 1 || d !== 32'h1100) begin
            errors++;
            $display("FAIL evict_fill: got stall %0d evict %0d data %h expected 11 1 00001100",
                     st, ev, d);
        end
        foreach (addrs[i]) begin
            fetch(addrs[i], st, d, ms, ev, h);
            checks++;
            if (st !== 0 || h !== 1'b1) begin
                errors++;
                $display("FAIL survivor %h: got stall %0d hit %b expected 0 1",
                         addrs[i], st, h);
            end
        end
        fetch(32'h000, st, d, ms, ev, h);
        checks++;
        if (st !== 11 || ms !== 1 || d !== 32'h1000) begin
            errors++;
            $display("FAIL evicted_refetch: got stall %0d miss %0d data %h expected 11 1 00001000",
                     st, ms, d);
        end
    endtask

    task automatic test_reset_midfill();
        int          st, ms, ev;
        logic [31:0] d;
        logic        h;
        cpu_req = 1'b1;
        cpu_addr = 32'h40;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (mem_addr !== 32'h4C) begin
            errors++;
            $display("FAIL midfill_beat: got %h expected 0000004c", mem_addr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || mem_addr !== 32'h0 || cpu_data !== NOP) begin
            errors++;
            $display("FAIL midfill_reset: got stall %b mem_addr %h data %h expected 0 0 %h",
                     cpu_stall, mem_addr, cpu_data, NOP);
        end
        @(negedge clk);
        rst = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        fetch(32'h40, st, d, ms, ev, h);
        checks++;
        if (st !== 11 || ms !== 1 || d !== 32'h1010) begin
            errors++;
            $display("FAIL post_reset_fetch: got stall %0d miss %0d data %h expected 11 1 00001010",
                     st, ms, d);
        end
        fetch(32'h100, st, d, ms, ev, h);
        checks++;
        if (st !== 11) begin
            errors++;
            $display("FAIL post_reset_invalid: got stall %0d expected 11", st);
        end
    endtask

    task automatic test_load_use();
        cpu_req = 1'b1;
        cpu_addr = 32'h80;
        load_use_stall_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (cache_miss !== 1'b0 || mem_addr !== 32'h0 || cpu_stall !== 1'b1) begin
                errors++;
                $display("FAIL lu_hold c%0d: got miss %b mem_addr %h stall %b expected 0 0 1",
                         k, cache_miss, mem_addr, cpu_stall);
            end
            @(negedge clk);
        end
        load_use_stall_in = 1'b0;
        #1;
        checks++;
        if (cache_miss !== 1'b1) begin
            errors++;
            $display("FAIL lu_release_miss: got %b expected 1", cache_miss);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_addr !== 32'h0 || cache_miss !== 1'b0) begin
            errors++;
            $display("FAIL lu_req_cycle: got mem_addr %h miss %b expected 0 0",
                     mem_addr, cache_miss);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_addr !== 32'h80) begin
            errors++;
            $display("FAIL lu_first_beat: got %h expected 00000080", mem_addr);
        end
        repeat (9) @(negedge clk);
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || cpu_data !== 32'h1020) begin
            errors++;
            $display("FAIL lu_hit: got stall %b data %h expected 0 00001020",
                     cpu_stall, cpu_data);
        end
        load_use_stall_in = 1'b1;
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || cpu_data !== 32'h1020 || cache_hit !== 1'b0) begin
            errors++;
            $display("FAIL lu_frozen_hit: got stall %b data %h hit %b expected 0 00001020 0",
                     cpu_stall, cpu_data, cache_hit);
        end
        @(negedge clk);
        cpu_req = 1'b0;
        load_use_stall_in = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_seq_hits();
        test_evict();
        test_reset_midfill();
        test_load_use();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
